mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
Round-robin scheduler that shares one line-granular memory engine (the AXI line fill/writeback bus engine) between N cache-side requesters: I-cache, D-cache and writeback buffer.
It accepts one whole-line load or store command at a time, forwards it to the engine, collects the completion and returns it to the owning requester.
It also flags a returned load line as stale when a snoop invalidate hits it while in flight.
It sits between the caches and the bus engine, so each cache sees a private command/response port.

Parameters:
N_REQ, 4, number of requester ports (2..8)
ADDR_WIDTH, 64, byte address width
LINE_WIDTH, 512, cache line width in bits
LINE_OFF, $clog2(LINE_WIDTH/8), byte-offset bits ignored in line-address compares
ID_W, $clog2(N_REQ), requester index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  N_REQ  per-requester command valid; held until accepted
req_store  in  N_REQ  1 = line writeback, 0 = line fill
req_addr  in  N_REQ x ADDR_WIDTH  command address
req_data  in  N_REQ x LINE_WIDTH  store data
req_ready  out  N_REQ  one-hot accept; handshake = req_valid & req_ready
resp_valid  out  N_REQ  one-hot completion to owner
resp_rready  in  N_REQ  owner accepts completion
resp_data  out  LINE_WIDTH  fill data (zero for stores)
resp_stale  out  1  returned fill line was invalidated in flight
grant_id  out  ID_W  current owner index (valid when busy)
busy  out  1  state != IDLE
eng_cmd_valid  out  1  command to engine
eng_cmd_ready  in  1  engine accepts command
eng_cmd_store, eng_cmd_addr, eng_cmd_data  out  1/ADDR_WIDTH/LINE_WIDTH  latched command
eng_done_valid  in  1  engine completion
eng_done_data  in  LINE_WIDTH  fill data
eng_done_ready  out  1  arbiter accepts completion
inv_valid  in  1  snoop invalidate pulse
inv_addr  in  ADDR_WIDTH  invalidate address

Behaviour:
- Reset: state IDLE, rr_ptr 0, all outputs 0, latched command/data cleared. Reset mid-transaction abandons it; no response is issued, and the engine must be reset in the same cycle.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE: winner = first index i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready = onehot(winner), combinational, asserted only in IDLE and only when any req_valid.
  - On handshake: latch owner, store, addr, data; clear stale; go to ISSUE.
  - No valid requests: stay in IDLE, req_ready = 0.
- ISSUE: eng_cmd_valid = 1, payload from latches, stable until eng_cmd_ready. On ready, go to BUSY.
- BUSY: eng_done_ready = 1. On eng_done_valid:
  - latch eng_done_data for loads, 0 for stores;
  - go to RESP.
- RESP: resp_valid = onehot(owner), resp_data and resp_stale stable. On resp_rready[owner]:
  - go to IDLE;
  - rr_ptr = owner+1 mod N_REQ (wraps N_REQ-1 -> 0).
  - resp_rready of non-owners is ignored.
- Latency: accept at cycle T, eng_cmd_valid at T+1. eng_done_valid at cycle D gives resp_valid at D+1. RESP exit to next accept takes at least 1 cycle (IDLE).
- Stale tracking: in ISSUE, BUSY or RESP with store = 0, stale is set when inv_valid and inv_addr[ADDR_WIDTH-1:LINE_OFF] == addr[ADDR_WIDTH-1:LINE_OFF]. Once set it stays set until the next accept.
  - Invalidate in the same cycle as eng_done_valid: stale is set.
  - Invalidate in the accept cycle is not captured.
  - Stores never set stale.
- Fairness: a continuously asserted requester is granted within N_REQ transactions.
- grant_id = owner and busy = 1 in ISSUE, BUSY and RESP; grant_id = 0 in IDLE.

Test Plan:
1. Single load: N_REQ=4, req_valid=0010, addr 0x1040, engine ready after 2 cycles, done data 0xA5.. -> req_ready=0010 for 1 cycle; eng_cmd_addr=0x1040 with eng_cmd_store=0; resp_valid=0010 with resp_data=0xA5.., resp_stale=0; rr_ptr becomes 2.
2. Round-robin: all four req_valid held high, rr_ptr=0, engine responds immediately -> grant order 0,1,2,3,0, with at least one IDLE cycle between grants.
3. Wrap: rr_ptr=3, req_valid=1001 -> grant 3 first, then 0; rr_ptr goes 3 -> 0 -> 1.
4. Store: req_store=1, addr 0x2000, data 0x11.. -> eng_cmd_data=0x11..; on done, resp_data=0 and resp_stale=0 even if inv_addr=0x2000 fires in BUSY.
5. Stale: load 0x3000, inv_valid with inv_addr 0x3038 in BUSY -> resp_stale=1. Repeat with inv_addr 0x3040 -> resp_stale=0. Repeat with inv in the eng_done_valid cycle -> resp_stale=1.
6. Backpressure and reset: hold resp_rready=0 for 5 cycles -> resp_valid and resp_data stable, no new req_ready. Assert reset in BUSY -> next cycle all outputs 0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin scheduler that shares one line-granular memory
// engine between N_REQ cache-side requesters. One whole-line command is in
// flight at a time. A fill that a snoop invalidate hits while it is in flight
// is returned marked stale.
module mem_req_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512,
    parameter int LINE_OFF   = $clog2(LINE_WIDTH / 8),
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    // requester command ports
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [N_REQ-1:0]                      req_store,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      req_addr,
    input  logic [N_REQ-1:0][LINE_WIDTH-1:0]      req_data,
    output logic [N_REQ-1:0]                      req_ready,
    // requester response ports
    output logic [N_REQ-1:0]                      resp_valid,
    input  logic [N_REQ-1:0]                      resp_rready,
    output logic [LINE_WIDTH-1:0]                 resp_data,
    output logic                                  resp_stale,
    // status
    output logic [ID_W-1:0]                       grant_id,
    output logic                                  busy,
    // engine command channel
    output logic                                  eng_cmd_valid,
    input  logic                                  eng_cmd_ready,
    output logic                                  eng_cmd_store,
    output logic [ADDR_WIDTH-1:0]                 eng_cmd_addr,
    output logic [LINE_WIDTH-1:0]                 eng_cmd_data,
    // engine completion channel
    input  logic                                  eng_done_valid,
    input  logic [LINE_WIDTH-1:0]                 eng_done_data,
    output logic                                  eng_done_ready,
    // snoop invalidate
    input  logic                                  inv_valid,
    input  logic [ADDR_WIDTH-1:0]                 inv_addr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin successor: N_REQ-1 wraps back to 0.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
        logic [ID_W-1:0] n;
        if (p == ID_W'(N_REQ - 1)) begin
            n = {ID_W{1'b0}};
        end else begin
            n = p + ID_W'(1);
        end
        return n;
    endfunction

    // Line-granular address compare; byte-offset bits do not matter.
    function automatic logic same_line(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] b);
        return (a[ADDR_WIDTH-1:LINE_OFF] == b[ADDR_WIDTH-1:LINE_OFF]);
    endfunction

    state_t                 state_r;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [ID_W-1:0]        owner_r;
    logic                   store_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [LINE_WIDTH-1:0]  data_r;
    logic                   stale_r;
    logic [LINE_WIDTH-1:0]  resp_data_r;
    logic [N_REQ-1:0]       resp_valid_r;
    logic                   eng_cmd_valid_r;
    logic                   eng_done_ready_r;
    logic                   busy_r;
    logic [ID_W-1:0]        grant_id_r;

    logic                   win_found_s;
    logic [ID_W-1:0]        win_idx_s;
    logic [ID_W-1:0]        cand_idx_s;
    int                     cand_s;
    logic                   accept_s;
    logic                   stale_hit_s;
    logic                   unused_s;

    // Pick the first valid requester scanning from rr_ptr upward, modulo N_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {ID_W{1'b0}};
        cand_s      = 0;
        cand_idx_s  = {ID_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            cand_s     = (int'(rr_ptr_r) + k) % N_REQ;
            cand_idx_s = ID_W'(cand_s);
            if (!win_found_s && req_valid[cand_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Accept is offered only while idle, and only to the round-robin winner.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        if ((state_r == ST_IDLE) && win_found_s) begin
            req_ready = onehot(win_idx_s);
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // req_ready only ever points at a valid requester, so a winner means a handshake.
    assign accept_s = (state_r == ST_IDLE) && win_found_s;

    // A snoop hits an in-flight fill to the same line; stores and idle cycles are exempt.
    assign stale_hit_s = inv_valid && !store_r && (state_r != ST_IDLE) &&
                         same_line(inv_addr, addr_r);

    // Byte-offset bits of the snoop address take no part in the line compare.
    assign unused_s = ^inv_addr[LINE_OFF-1:0];

    // Transaction FSM: owns the latched command, the response and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            rr_ptr_r         <= {ID_W{1'b0}};
            owner_r          <= {ID_W{1'b0}};
            store_r          <= 1'b0;
            addr_r           <= {ADDR_WIDTH{1'b0}};
            data_r           <= {LINE_WIDTH{1'b0}};
            stale_r          <= 1'b0;
            resp_data_r      <= {LINE_WIDTH{1'b0}};
            resp_valid_r     <= {N_REQ{1'b0}};
            eng_cmd_valid_r  <= 1'b0;
            eng_done_ready_r <= 1'b0;
            busy_r           <= 1'b0;
            grant_id_r       <= {ID_W{1'b0}};
        end else begin
            if (stale_hit_s) begin
                stale_r <= 1'b1;
            end else begin
                stale_r <= stale_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r         <= win_idx_s;
                        store_r         <= req_store[win_idx_s];
                        addr_r          <= req_addr[win_idx_s];
                        data_r          <= req_data[win_idx_s];
                        stale_r         <= 1'b0;
                        eng_cmd_valid_r <= 1'b1;
                        busy_r          <= 1'b1;
                        grant_id_r      <= win_idx_s;
                        state_r         <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (eng_cmd_ready) begin
                        eng_cmd_valid_r  <= 1'b0;
                        eng_done_ready_r <= 1'b1;
                        state_r          <= ST_BUSY;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_BUSY: begin
                    if (eng_done_valid) begin
                        if (store_r) begin
                            resp_data_r <= {LINE_WIDTH{1'b0}};
                        end else begin
                            resp_data_r <= eng_done_data;
                        end
                        eng_done_ready_r <= 1'b0;
                        resp_valid_r     <= onehot(owner_r);
                        state_r          <= ST_RESP;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_RESP: begin
                    if (resp_rready[owner_r]) begin
                        resp_valid_r <= {N_REQ{1'b0}};
                        busy_r       <= 1'b0;
                        grant_id_r   <= {ID_W{1'b0}};
                        rr_ptr_r     <= next_ptr(owner_r);
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    resp_valid_r     <= {N_REQ{1'b0}};
                    eng_cmd_valid_r  <= 1'b0;
                    eng_done_ready_r <= 1'b0;
                    busy_r           <= 1'b0;
                    grant_id_r       <= {ID_W{1'b0}};
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid     = resp_valid_r;
    assign resp_data      = resp_data_r;
    assign resp_stale     = stale_r;
    assign grant_id       = grant_id_r;
    assign busy           = busy_r;
    assign eng_cmd_valid  = eng_cmd_valid_r;
    assign eng_cmd_store  = store_r;
    assign eng_cmd_addr   = addr_r;
    assign eng_cmd_data   = data_r;
    assign eng_done_ready = eng_done_ready_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios for the round-robin line-request arbiter.
module tb_mem_req_arbiter;

    localparam int N    = 4;
    localparam int AW   = 64;
    localparam int LW   = 512;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_store;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][LW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         resp_valid;
    logic [N-1:0]         resp_rready;
    logic [LW-1:0]        resp_data;
    logic                 resp_stale;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    logic                 eng_cmd_valid;
    logic                 eng_cmd_ready;
    logic                 eng_cmd_store;
    logic [AW-1:0]        eng_cmd_addr;
    logic [LW-1:0]        eng_cmd_data;
    logic                 eng_done_valid;
    logic [LW-1:0]        eng_done_data;
    logic                 eng_done_ready;
    logic                 inv_valid;
    logic [AW-1:0]        inv_addr;

    int tests_run = 0;
    int tests_failed = 0;

    mem_req_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rready(resp_rready),
        .resp_data(resp_data), .resp_stale(resp_stale),
        .grant_id(grant_id), .busy(busy),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
        .eng_cmd_store(eng_cmd_store), .eng_cmd_addr(eng_cmd_addr),
        .eng_cmd_data(eng_cmd_data),
        .eng_done_valid(eng_done_valid), .eng_done_data(eng_done_data),
        .eng_done_ready(eng_done_ready),
        .inv_valid(inv_valid), .inv_addr(inv_addr)
    );

    always #5 clk = ~clk;

    // advance one clock; inputs change 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic eng_take();
        eng_cmd_ready = 1'b1;
        step();
        eng_cmd_ready = 1'b0;
    endtask

    task automatic eng_finish(input logic [LW-1:0] d, input logic iv, input logic [AW-1:0] ia);
        eng_done_valid = 1'b1;
        eng_done_data  = d;
        inv_valid      = iv;
        inv_addr       = ia;
        step();
        eng_done_valid = 1'b0;
        eng_done_data  = '0;
        inv_valid      = 1'b0;
    endtask

    task automatic owner_take(input logic [N-1:0] m);
        resp_rready = m;
        step();
        resp_rready = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({busy, eng_cmd_valid, eng_done_ready, resp_stale, eng_cmd_store} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, eng_cmd_valid, eng_done_ready, resp_stale, eng_cmd_store});
        end
        tests_run++;
        if ({req_ready, resp_valid, grant_id} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_vectors: got %h expected 0", {req_ready, resp_valid, grant_id});
        end
        tests_run++;
        if (resp_data !== {LW{1'b0}} || eng_cmd_addr !== {AW{1'b0}} || eng_cmd_data !== {LW{1'b0}}) begin
            tests_failed++;
            $display("FAIL reset_payload: got addr %h expected 0", eng_cmd_addr);
        end
    endtask

    task automatic test_single_load();
        req_valid = 4'b0010; req_store = 4'b0000; req_addr[1] = 64'h1040;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL load_ready: got %b expected 0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000 || eng_cmd_valid !== 1'b1 || eng_cmd_store !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_issue: got ready %b cmd_valid %b store %b expected 0000 1 0",
                     req_ready, eng_cmd_valid, eng_cmd_store);
        end
        tests_run++;
        if (eng_cmd_addr !== 64'h1040 || grant_id !== 2'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_cmd_addr: got %h id %0d expected 1040 id 1", eng_cmd_addr, grant_id);
        end
        step();
        step();
        tests_run++;
        if (eng_cmd_valid !== 1'b1 || eng_cmd_addr !== 64'h1040) begin
            tests_failed++;
            $display("FAIL load_cmd_hold: got valid %b addr %h expected 1 1040", eng_cmd_valid, eng_cmd_addr);
        end
        eng_take();
        #1;
        tests_run++;
        if (eng_cmd_valid !== 1'b0 || eng_done_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_busy: got cmd_valid %b done_ready %b expected 0 1", eng_cmd_valid, eng_done_ready);
        end
        eng_finish({64{8'hA5}}, 1'b0, 64'h0);
        #1;
        tests_run++;
        if (resp_valid !== 4'b0010 || resp_data !== {64{8'hA5}} || resp_stale !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_resp: got valid %b stale %b data %h expected 0010 0 a5..",
                     resp_valid, resp_stale, resp_data);
        end
        owner_take(4'b0010);
        #1;
        tests_run++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL load_done: got valid %b busy %b expected 0000 0", resp_valid, busy);
        end
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL load_rr_ptr: got %b expected 0100", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        req_valid = 4'b1111; req_store = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            #1;
            tests_run++;
            if (busy !== 1'b0 || req_ready !== exp) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got ready %b busy %b expected %b 0", k, req_ready, busy, exp);
            end
            step();
            #1;
            tests_run++;
            if (grant_id !== 2'(k % 4) || req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rr_owner%0d: got %0d expected %0d", k, grant_id, k % 4);
            end
            eng_take();
            eng_finish({64{8'h3C}}, 1'b0, 64'h0);
            owner_take(exp);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        // rr_ptr is 1 here; one grant to requester 2 moves it to 3
        req_valid = 4'b0100; req_addr[2] = 64'h0;
        step();
        req_valid = 4'b0000;
        eng_take();
        eng_finish({64{8'h01}}, 1'b0, 64'h0);
        owner_take(4'b0100);
        req_valid = 4'b1001;
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++; $display("FAIL wrap_first: got %b expected 1000", req_ready);
        end
        step();
        req_valid = 4'b0001;
        eng_take();
        eng_finish({64{8'h02}}, 1'b0, 64'h0);
        owner_take(4'b1000);
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL wrap_ptr0: got %b expected 0001", req_ready);
        end
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        #1;
        tests_run++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL wrap_second: got %0d expected 0", grant_id);
        end
        eng_take();
        eng_finish({64{8'h03}}, 1'b0, 64'h0);
        owner_take(4'b0001);
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL wrap_ptr1: got %b expected 0010", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_store();
        req_valid = 4'b0001; req_store = 4'b0001;
        req_addr[0] = 64'h2000; req_data[0] = {64{8'h11}};
        step();
        req_valid = 4'b0000; req_store = 4'b0000;
        #1;
        tests_run++;
        if (eng_cmd_store !== 1'b1 || eng_cmd_data !== {64{8'h11}} || eng_cmd_addr !== 64'h2000) begin
            tests_failed++;
            $display("FAIL store_cmd: got store %b data %h expected 1 11..", eng_cmd_store, eng_cmd_data);
        end
        eng_take();
        inv_valid = 1'b1; inv_addr = 64'h2000;
        step();
        inv_valid = 1'b0;
        eng_finish({64{8'hFF}}, 1'b1, 64'h2000);
        #1;
        tests_run++;
        if (resp_valid !== 4'b0001 || resp_data !== {LW{1'b0}} || resp_stale !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_resp: got valid %b stale %b data %h expected 0001 0 0",
                     resp_valid, resp_stale, resp_data);
        end
        owner_take(4'b0001);
    endtask

    task automatic test_stale();
        // when: 0 = invalidate in BUSY, 1 = with eng_done_valid, 2 = in the accept cycle
        int          when_t [4] = '{0, 0, 1, 2};
        logic [AW-1:0] addr_t [4] = '{64'h3038, 64'h3040, 64'h3000, 64'h3000};
        logic        exp_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b0100; req_store = 4'b0000; req_addr[2] = 64'h3000;
            if (when_t[c] == 2) begin
                inv_valid = 1'b1; inv_addr = addr_t[c];
            end
            step();
            req_valid = 4'b0000; inv_valid = 1'b0;
            eng_take();
            if (when_t[c] == 0) begin
                inv_valid = 1'b1; inv_addr = addr_t[c];
                step();
                inv_valid = 1'b0;
            end
            eng_finish({64{8'h5A}}, (when_t[c] == 1), addr_t[c]);
            #1;
            tests_run++;
            if (resp_stale !== exp_t[c] || resp_data !== {64{8'h5A}}) begin
                tests_failed++;
                $display("FAIL stale_case%0d: got %b expected %b", c, resp_stale, exp_t[c]);
            end
            owner_take(4'b0100);
        end
    endtask

    task automatic test_backpressure_reset();
        // rr_ptr is 3 after the stale cases
        req_valid = 4'b0100; req_addr[2] = 64'h4000;
        step();
        req_valid = 4'b0000;
        eng_take();
        eng_finish({64{8'hC3}}, 1'b0, 64'h0);
        req_valid = 4'b0011; resp_rready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (resp_valid !== 4'b0100 || resp_data !== {64{8'hC3}} || req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got valid %b ready %b expected 0100 0000", i, resp_valid, req_ready);
            end
            step();
        end
        resp_rready = 4'b0100;
        step();
        resp_rready = 4'b0000;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL bp_release: got %b expected 0001", req_ready);
        end
        req_valid = 4'b0000;
        step();
        // rr_ptr is 3; abandon a transaction from requester 1 in BUSY
        req_valid = 4'b0010; req_addr[1] = 64'h5000;
        step();
        req_valid = 4'b0000;
        eng_take();
        #1;
        tests_run++;
        if (eng_done_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rst_in_busy: got %b expected 1", eng_done_ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({busy, eng_done_ready, eng_cmd_valid, resp_valid, grant_id, req_ready} !== 13'd0 ||
            resp_data !== {LW{1'b0}} || eng_cmd_addr !== {AW{1'b0}}) begin
            tests_failed++;
            $display("FAIL rst_outputs: got busy %b done_ready %b id %0d addr %h expected all 0",
                     busy, eng_done_ready, grant_id, eng_cmd_addr);
        end
        step();
        tests_run++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL rst_no_resp: got %b expected 0000", resp_valid);
        end
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL rst_rr_ptr: got %b expected 0001", req_ready);
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_store = '0; req_addr = '0; req_data = '0;
        resp_rready = '0; eng_cmd_ready = 1'b0; eng_done_valid = 1'b0; eng_done_data = '0;
        inv_valid = 1'b0; inv_addr = '0;
        #2;
        test_reset();
        test_single_load();
        test_round_robin();
        test_wrap();
        test_store();
        test_stale();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
